dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store unit that consumes the data-memory command codes issued by the instruction decoder: ReadControl/WriteControl, with funct3 encoding and 7 meaning "none".
- Executes each command on a word-wide, handshaked data-memory bus.
- Does byte-lane steering, splits misaligned accesses into two bus transactions, and sign/zero-extends load data.
- Sits between the execute stage (address = ALU result, store data = rs2) and the data memory.

Parameters:
- ADDR_W, 32, byte-address width; bus word address is ADDR_W-2 bits.
- ALLOW_MISALIGN, 1, 1 = split word-crossing accesses into two transactions; 0 = flag them as errors with no bus access.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- lsu_valid  in  1  command present; sampled only when busy=0.
- ReadControl  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU, 7 none.
- WriteControl  in  3  store type: 0 SB, 1 SH, 2 SW, 7 none.
- lsu_addr  in  ADDR_W  byte address.
- lsu_wdata  in  32  store data, right-justified.
- busy  out  1  command in progress.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_err  out  1  valid only with lsu_done; illegal or disallowed command.
- lsu_rdata  out  32  extended load result; held until the next load completes.
- mem_req  out  1  bus request; held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W-2  word address.
- mem_wdata  out  32  lane-aligned write data.
- mem_wstrb  out  4  byte enables; bit i enables byte i, little-endian.
- mem_rdata  in  32  read data; valid when mem_ack=1 for a read.
- mem_ack  in  1  transfer complete; meaningful only while mem_req=1.

Behaviour:
- Reset (rst=0), asynchronous: every output goes to 0 immediately; FSM goes to IDLE. Reset mid-operation aborts the transaction: no done pulse, lsu_rdata cleared.
- FSM states: IDLE, REQ1, REQ2, DONE. busy=1 in every state except IDLE.
- IDLE:
  - Accept when lsu_valid=1 and ReadControl!=7 or WriteControl!=7. Latch type, address, data.
  - Both controls at 7: no action.
- Illegal command goes directly to DONE with lsu_err=1 and no bus cycle. Illegal means any of:
  - both controls != 7;
  - ReadControl in {3, 6};
  - WriteControl in {3..6};
  - misaligned access while ALLOW_MISALIGN=0.
- Legal command goes to REQ1. From the next cycle: mem_req=1, mem_addr=A (A = lsu_addr[ADDR_W-1:2]), mem_we=store, low-word strobes/data.
- REQ1 / REQ2: hold all mem_* outputs stable until mem_ack=1 is sampled at a rising edge.
  - After REQ1 ack: go to REQ2 if split, else DONE.
  - REQ2 drives mem_addr=A+1, wrapping modulo 2^(ADDR_W-2), with high-word strobes/data.
  - mem_req deasserts in the cycle after the final ack.
- DONE: lsu_done=1 for exactly one cycle; lsu_rdata updated in the same cycle for loads; then IDLE.
  - Minimum latency with zero-wait ack: accept at edge 0, done visible in cycle 2 (aligned) or cycle 3 (split).
- lsu_valid while busy=1 is ignored; no queuing.
- Lane rules, with off = lsu_addr[1:0]:
  - Size mask: B=0001, H=0011, W=1111.
  - 8-bit strobe vector = mask << off; low nibble goes to REQ1, high nibble to REQ2.
  - 64-bit write vector = {32'b0, wdata} << 8*off; low word goes to REQ1, high word to REQ2.
  - Split happens when the high nibble is nonzero: SH/LH/LHU at off=3; SW/LW at off!=0.
  - Reads drive mem_wstrb = the same lane mask (informational) and mem_wdata=0.
- Load combine: {rdata2, rdata1} >> 8*off, where rdata2=0 when not split.
  - Take the low byte/half and extend: LB/LH sign-extend; LBU/LHU zero-extend; LW as is.
- Stores leave lsu_rdata unchanged.
- Error completions leave lsu_rdata unchanged.

Test Plan:
1. SW addr 0x100, data 0xDEADBEEF, mem_ack returned in the first req cycle -> single write: mem_addr 0x40, wstrb 1111, wdata 0xDEADBEEF; lsu_done in cycle 2, err=0.
2. LB addr 0x103, mem_rdata 0x80123456 -> lsu_rdata 0xFFFFFF80. LBU same address -> 0x00000080. LHU addr 0x102 -> 0x00008012.
3. SW addr 0x102, data 0x11223344 (ALLOW_MISALIGN=1) -> write 1: addr 0x40, strb 1100, wdata 0x33440000; write 2: addr 0x41, strb 0011, wdata 0x00001122; one done pulse.
4. LH addr 0x107, with mem_ack held low 3 cycles per transfer; word 0x41 = 0xAB000000, word 0x42 = 0x000000CD -> mem_req/addr stable during waits; lsu_rdata 0xFFFFCDAB.
5. Error cases, all giving lsu_done=1, lsu_err=1, mem_req never asserted, lsu_rdata unchanged:
   - ReadControl=3;
   - both controls=2;
   - SW addr 0x101 with ALLOW_MISALIGN=0.
6. rst driven low during REQ1 with ack withheld -> mem_req and busy fall immediately with no done pulse; after release, SB addr 0x001, data 0xA5 -> strb 0010, wdata 0x0000A500.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit between the execute stage and a word-wide handshaked data memory.
// Steers bytes into lanes, splits word-crossing accesses into two bus transfers and
// sign/zero-extends load data. Command codes follow the decoder's funct3 encoding, 7 = none.
module dmem_lsu #(
   parameter int ADDR_W         = 32,
   parameter bit ALLOW_MISALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lsu_valid,
   input  logic [2:0]        ReadControl,
   input  logic [2:0]        WriteControl,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [31:0]       lsu_wdata,
   output logic              busy,
   output logic              lsu_done,
   output logic              lsu_err,
   output logic [31:0]       lsu_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   localparam int WA = ADDR_W - 2;
   localparam logic [WA-1:0] WORD_ONE = WA'(1);

   typedef enum logic [1:0] {S_IDLE, S_REQ1, S_REQ2, S_DONE} state_t;

   state_t          state_q, state_d;
   logic            store_q, store_d;
   logic [2:0]      rc_q, rc_d;
   logic [1:0]      off_q, off_d;
   logic            split_q, split_d;
   logic [3:0]      strb_hi_q, strb_hi_d;
   logic [31:0]     wdata_hi_q, wdata_hi_d;
   logic [31:0]     rdata1_q, rdata1_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [WA-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]     mem_wdata_q, mem_wdata_d;
   logic [3:0]      mem_wstrb_q, mem_wstrb_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;

   // Decoded view of the incoming command
   logic        rd_none, wr_none, cmd_store, is_split, illegal;
   logic [1:0]  size;
   logic [3:0]  mask4;
   logic [7:0]  strb8;
   logic [63:0] wvec;

   // Load result assembled from one or two bus words
   logic [63:0] load_pair;
   logic [31:0] load_shift;
   logic [31:0] load_ext;

   // Classify the command and compute its lane strobes and lane-aligned store data
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      rd_none   = (ReadControl == 3'd7);
      wr_none   = (WriteControl == 3'd7);
      cmd_store = !wr_none;
      size      = cmd_store ? WriteControl[1:0] : ReadControl[1:0];
      case (size)
         2'd0:    mask4 = 4'b0001;
         2'd1:    mask4 = 4'b0011;
         default: mask4 = 4'b1111;
      endcase
      strb8    = {4'b0000, mask4} << lsu_addr[1:0];
      wvec     = {32'b0, lsu_wdata} << {lsu_addr[1:0], 3'b000};
      is_split = |strb8[7:4];
      illegal  = (!rd_none && !wr_none)
              || (wr_none && (ReadControl == 3'd3 || ReadControl == 3'd6))
              || (rd_none && (WriteControl inside {3'd3, 3'd4, 3'd5, 3'd6}))
              || (is_split && !ALLOW_MISALIGN);
   end

   // Combine the returned word(s), shift the addressed bytes down and extend them
   always_comb begin
      load_pair  = split_q ? {mem_rdata, rdata1_q} : {32'b0, mem_rdata};
      load_shift = 32'(load_pair >> {off_q, 3'b000});
      case (rc_q)
         3'd0:    load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
         3'd1:    load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
         3'd4:    load_ext = {24'b0, load_shift[7:0]};
         3'd5:    load_ext = {16'b0, load_shift[15:0]};
         default: load_ext = load_shift;
      endcase
   end

   // Next-state and next-output logic of the command FSM
   always_comb begin
      state_d     = state_q;
      store_d     = store_q;
      rc_d        = rc_q;
      off_d       = off_q;
      split_d     = split_q;
      strb_hi_d   = strb_hi_q;
      wdata_hi_d  = wdata_hi_q;
      rdata1_d    = rdata1_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (lsu_valid && !(rd_none && wr_none)) begin
               store_d    = cmd_store;
               rc_d       = ReadControl;
               off_d      = lsu_addr[1:0];
               split_d    = is_split;
               strb_hi_d  = strb8[7:4];
               wdata_hi_d = cmd_store ? wvec[63:32] : 32'b0;
               if (illegal) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d     = S_REQ1;
                  mem_req_d   = 1'b1;
                  mem_we_d    = cmd_store;
                  mem_addr_d  = lsu_addr[ADDR_W-1:2];
                  mem_wstrb_d = strb8[3:0];
                  mem_wdata_d = cmd_store ? wvec[31:0] : 32'b0;
               end
            end
         end
         S_REQ1, S_REQ2: begin
            if (mem_ack) begin
               if (state_q == S_REQ1 && split_q) begin
                  state_d     = S_REQ2;
                  rdata1_d    = mem_rdata;
                  mem_addr_d  = mem_addr_q + WORD_ONE;
                  mem_wstrb_d = strb_hi_q;
                  mem_wdata_d = wdata_hi_q;
               end else begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  mem_req_d   = 1'b0;
                  mem_we_d    = 1'b0;
                  mem_wstrb_d = 4'b0000;
                  mem_wdata_d = 32'b0;
                  if (!store_q) rdata_d = load_ext;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any transfer and clears every output
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         store_q     <= 1'b0;
         rc_q        <= 3'd7;
         off_q       <= 2'd0;
         split_q     <= 1'b0;
         strb_hi_q   <= 4'b0000;
         wdata_hi_q  <= 32'b0;
         rdata1_q    <= 32'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'b0;
         mem_wstrb_q <= 4'b0000;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= 32'b0;
      end else begin
         // NOTE: non-blocking here so every flop samples the pre-edge values of the others.
         state_q     <= state_d;
         store_q     <= store_d;
         rc_q        <= rc_d;
         off_q       <= off_d;
         split_q     <= split_d;
         strb_hi_q   <= strb_hi_d;
         wdata_hi_q  <= wdata_hi_d;
         rdata1_q    <= rdata1_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign lsu_done  = done_q;
   assign lsu_err   = err_q;
   assign lsu_rdata = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: expected bus transfers and completions are queued
// when a command is issued and compared when the DUT drives the bus or pulses done.
module tb_dmem_lsu;

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } bus_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } cmp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        lsu_valid = 1'b0;
   logic        lsu_valid_na = 1'b0;
   logic [2:0]  read_control = 3'd7;
   logic [2:0]  write_control = 3'd7;
   logic [31:0] lsu_addr = 32'h0;
   logic [31:0] lsu_wdata = 32'h0;
   logic        busy, lsu_done, lsu_err;
   logic [31:0] lsu_rdata;
   logic        mem_req, mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ack = 1'b0;

   logic        busy_na, lsu_done_na, lsu_err_na;
   logic [31:0] lsu_rdata_na;
   logic        mem_req_na, mem_we_na;
   logic [29:0] mem_addr_na;
   logic [31:0] mem_wdata_na;
   logic [3:0]  mem_wstrb_na;
   logic        mem_ack_na;
   logic [31:0] mem_rdata_na = 32'h0;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;
   int last_accept_cyc = 0;
   int ack_delay = 0;
   logic [31:0] last_load = 32'h0;
   logic [31:0] mem_model [int];
   bus_t bus_q[$];
   cmp_t cmp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mem_ack_na = mem_req_na;

   dmem_lsu #(.ADDR_W(32), .ALLOW_MISALIGN(1'b1)) dut (
      .clk(clk), .rst(rst), .lsu_valid(lsu_valid),
      .ReadControl(read_control), .WriteControl(write_control),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .busy(busy), .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   dmem_lsu #(.ADDR_W(32), .ALLOW_MISALIGN(1'b0)) dut_na (
      .clk(clk), .rst(rst), .lsu_valid(lsu_valid_na),
      .ReadControl(read_control), .WriteControl(write_control),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .busy(busy_na), .lsu_done(lsu_done_na), .lsu_err(lsu_err_na), .lsu_rdata(lsu_rdata_na),
      .mem_req(mem_req_na), .mem_we(mem_we_na), .mem_addr(mem_addr_na),
      .mem_wdata(mem_wdata_na), .mem_wstrb(mem_wstrb_na),
      .mem_rdata(mem_rdata_na), .mem_ack(mem_ack_na)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic exp_bus(input logic we, input logic [29:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata);
      bus_t b;
      b.we = we; b.addr = addr; b.strb = strb; b.wdata = wdata;
      bus_q.push_back(b);
   endtask

   task automatic exp_cmp(input logic err, input logic [31:0] rdata, input int lat);
      cmp_t c;
      c.err = err; c.rdata = rdata; c.lat = lat;
      cmp_q.push_back(c);
   endtask

   // Wait for the DUT to be idle, present one command for one accepting edge
   task automatic issue(input logic [2:0] rc, input logic [2:0] wc,
                        input logic [31:0] addr, input logic [31:0] wdata);
      int n;
      n = 0;
      @(posedge clk); #1;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) check("idle_timeout", {31'b0, busy}, 32'd0);
      read_control = rc; write_control = wc; lsu_addr = addr; lsu_wdata = wdata;
      lsu_valid = 1'b1;
      @(posedge clk); #1;
      last_accept_cyc = cyc;
      lsu_valid = 1'b0; read_control = 3'd7; write_control = 3'd7;
      check("busy_after_accept", {31'b0, busy}, 32'd1);
   endtask

   // Bounded wait for every queued completion to be seen
   task automatic wait_all();
      int n;
      n = 0;
      while (cmp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (cmp_q.size() != 0) begin
         check("done_timeout", cmp_q.size(), 32'd0);
         cmp_q.delete();
      end
   endtask

   // Error-path command on the no-misalign instance
   task automatic issue_na(input logic [2:0] rc, input logic [2:0] wc, input logic [31:0] addr);
      int n;
      @(posedge clk); #1;
      read_control = rc; write_control = wc; lsu_addr = addr; lsu_wdata = 32'h5555_AAAA;
      lsu_valid_na = 1'b1;
      @(posedge clk); #1;
      lsu_valid_na = 1'b0; read_control = 3'd7; write_control = 3'd7;
      n = 0;
      while (!lsu_done_na && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("na_done", {31'b0, lsu_done_na}, 32'd1);
      check("na_err", {31'b0, lsu_err_na}, 32'd1);
      check("na_rdata", lsu_rdata_na, 32'h0);
      @(posedge clk); #1;
      check("na_idle", {31'b0, busy_na}, 32'd0);
   endtask

   // Memory responder: compares each new transfer with the scoreboard, checks the
   // request holds steady while acks are withheld, then acks after ack_delay cycles
   initial begin
      bus_t e;
      logic in_xfer;
      int waited;
      logic [29:0] cur_addr;
      logic [31:0] cur_wdata;
      in_xfer = 1'b0; waited = 0; cur_addr = '0; cur_wdata = '0;
      forever begin
         @(negedge clk);
         if (mem_ack) begin
            mem_ack = 1'b0; mem_rdata = 32'h0; in_xfer = 1'b0;
         end
         if (!rst) begin
            in_xfer = 1'b0; mem_ack = 1'b0;
         end else if (mem_req) begin
            if (!in_xfer) begin
               in_xfer = 1'b1; waited = 0;
               cur_addr = mem_addr; cur_wdata = mem_wdata;
               if (bus_q.size() == 0) begin
                  check("bus_unexpected", {2'b0, mem_addr}, 32'hFFFF_FFFF);
               end else begin
                  e = bus_q.pop_front();
                  check("bus_we", {31'b0, mem_we}, {31'b0, e.we});
                  check("bus_addr", {2'b0, mem_addr}, {2'b0, e.addr});
                  check("bus_strb", {28'b0, mem_wstrb}, {28'b0, e.strb});
                  check("bus_wdata", mem_wdata, e.wdata);
               end
            end else begin
               check("hold_addr", {2'b0, mem_addr}, {2'b0, cur_addr});
               check("hold_wdata", mem_wdata, cur_wdata);
            end
            if (waited >= ack_delay) begin
               mem_ack = 1'b1;
               if (!mem_we)
                  mem_rdata = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : 32'h0;
            end else begin
               waited++;
            end
         end
      end
   end

   // Completion monitor
   initial begin
      cmp_t c;
      forever begin
         @(negedge clk);
         if (lsu_done) begin
            if (cmp_q.size() == 0) begin
               check("done_unexpected", {31'b0, lsu_done}, 32'd0);
            end else begin
               c = cmp_q.pop_front();
               check("done_err", {31'b0, lsu_err}, {31'b0, c.err});
               check("done_rdata", lsu_rdata, c.rdata);
               if (c.lat >= 0) check("done_latency", cyc - last_accept_cyc, c.lat);
            end
         end
      end
   end

   // No-misalign instance must never touch the bus
   initial begin
      forever begin
         @(negedge clk);
         if (mem_req_na) check("na_bus_req", {31'b0, mem_req_na}, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_done", {31'b0, lsu_done}, 32'd0);
      check("rst_rdata", lsu_rdata, 32'h0);
      check("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
      rst = 1'b1;

      // Aligned word store, zero-wait
      exp_bus(1'b1, 30'h40, 4'b1111, 32'hDEADBEEF);
      exp_cmp(1'b0, last_load, 1);
      issue(3'd7, 3'd2, 32'h100, 32'hDEADBEEF);
      wait_all();

      // Byte/half loads with extension
      mem_model[32'h40] = 32'h80123456;
      exp_bus(1'b0, 30'h40, 4'b1000, 32'h0);
      last_load = 32'hFFFFFF80; exp_cmp(1'b0, last_load, 1);
      issue(3'd0, 3'd7, 32'h103, 32'h0);
      exp_bus(1'b0, 30'h40, 4'b1000, 32'h0);
      last_load = 32'h00000080; exp_cmp(1'b0, last_load, 1);
      issue(3'd4, 3'd7, 32'h103, 32'h0);
      exp_bus(1'b0, 30'h40, 4'b1100, 32'h0);
      last_load = 32'h00008012; exp_cmp(1'b0, last_load, 1);
      issue(3'd5, 3'd7, 32'h102, 32'h0);
      wait_all();

      // Split word store
      exp_bus(1'b1, 30'h40, 4'b1100, 32'h33440000);
      exp_bus(1'b1, 30'h41, 4'b0011, 32'h00001122);
      exp_cmp(1'b0, last_load, 2);
      issue(3'd7, 3'd2, 32'h102, 32'h11223344);
      wait_all();

      // Split half load with wait states; a command offered while busy is ignored
      ack_delay = 3;
      mem_model[32'h41] = 32'hAB000000;
      mem_model[32'h42] = 32'h000000CD;
      exp_bus(1'b0, 30'h41, 4'b1000, 32'h0);
      exp_bus(1'b0, 30'h42, 4'b0001, 32'h0);
      last_load = 32'hFFFFCDAB; exp_cmp(1'b0, last_load, -1);
      issue(3'd1, 3'd7, 32'h107, 32'h0);
      write_control = 3'd2; lsu_addr = 32'h300; lsu_wdata = 32'h0BAD0BAD; lsu_valid = 1'b1;
      @(posedge clk); #1;
      lsu_valid = 1'b0; write_control = 3'd7;
      wait_all();
      ack_delay = 0;

      // Aligned word load, split half store, word load wrapping the top of memory
      exp_bus(1'b0, 30'h41, 4'b1111, 32'h0);
      last_load = 32'hAB000000; exp_cmp(1'b0, last_load, 1);
      issue(3'd2, 3'd7, 32'h104, 32'h0);
      exp_bus(1'b1, 30'h0, 4'b1000, 32'hEF000000);
      exp_bus(1'b1, 30'h1, 4'b0001, 32'h000000BE);
      exp_cmp(1'b0, last_load, 2);
      issue(3'd7, 3'd1, 32'h003, 32'h0000BEEF);
      mem_model[32'h3FFFFFFF] = 32'h55667788;
      mem_model[32'h0] = 32'h11223344;
      exp_bus(1'b0, 30'h3FFFFFFF, 4'b1100, 32'h0);
      exp_bus(1'b0, 30'h0, 4'b0011, 32'h0);
      last_load = 32'h33445566; exp_cmp(1'b0, last_load, 2);
      issue(3'd2, 3'd7, 32'hFFFFFFFE, 32'h0);
      wait_all();

      // Illegal commands: immediate error completion, no bus traffic
      exp_cmp(1'b1, last_load, 0);
      issue(3'd3, 3'd7, 32'h100, 32'h0);
      exp_cmp(1'b1, last_load, 0);
      issue(3'd2, 3'd2, 32'h100, 32'h0);
      exp_cmp(1'b1, last_load, 0);
      issue(3'd6, 3'd7, 32'h100, 32'h0);
      exp_cmp(1'b1, last_load, 0);
      issue(3'd7, 3'd4, 32'h100, 32'h0);
      wait_all();

      // Both controls at none: no action
      @(posedge clk); #1;
      lsu_valid = 1'b1; read_control = 3'd7; write_control = 3'd7;
      @(posedge clk); #1;
      lsu_valid = 1'b0;
      check("none_not_busy", {31'b0, busy}, 32'd0);

      // Word-crossing accesses rejected when misalignment is disallowed
      issue_na(3'd7, 3'd2, 32'h101);
      issue_na(3'd1, 3'd7, 32'h103);

      // Reset in REQ1 with ack withheld
      ack_delay = 1000;
      exp_bus(1'b0, 30'h80, 4'b1111, 32'h0);
      exp_cmp(1'b0, 32'h0, -1);
      issue(3'd2, 3'd7, 32'h200, 32'h0);
      @(posedge clk); #3;
      check("pre_rst_req", {31'b0, mem_req}, 32'd1);
      rst = 1'b0;
      #1;
      check("abort_req", {31'b0, mem_req}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, lsu_done}, 32'd0);
      check("abort_rdata", lsu_rdata, 32'h0);
      cmp_q.delete();
      ack_delay = 0;
      last_load = 32'h0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;

      // Byte store after reset
      exp_bus(1'b1, 30'h0, 4'b0010, 32'h0000A500);
      exp_cmp(1'b0, last_load, 1);
      issue(3'd7, 3'd0, 32'h001, 32'h000000A5);
      wait_all();

      repeat (3) @(negedge clk);
      check("bus_q_drained", bus_q.size(), 32'd0);
      check("cmp_q_drained", cmp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
